fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline, sitting directly upstream of decode and feeding the ID/EX register through decode. It owns the PC, drives a request/ready instruction-memory port, and holds the IF/ID pipeline register. The IF/ID register supports load-use stall from the hazard unit and branch/jump redirect-flush from EX. A two-state-plus-drain FSM buffers responses that arrive during a stall and discards stale in-flight responses after a redirect.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ready port and holds IF/ID.
// Responses arriving under stall are parked in a hold buffer; stale responses after a redirect are drained.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  input  logic        stall_ID,
  input  logic        flush_EX,
  input  logic [31:0] branchTarget_EX,
  output logic [31:0] pc_IFOut,
  output logic [31:0] pcPlus4_IFOut,
  output logic [31:0] instr_IFOut,
  output logic        valid_IFOut
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_buf_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // The address comes straight from pc_q, so it stays stable while a request is outstanding.
  assign imemReq  = (state_q != StHold);
  assign imemAddr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      hold_buf_q    <= 32'h0;
      redirect_pc_q <= 32'h0;
      pc_IFOut      <= 32'h0;
      pcPlus4_IFOut <= 32'h0;
      instr_IFOut   <= NOP_INSTR;
      valid_IFOut   <= 1'b0;
    end else if (flush_EX) begin
      // Redirect overrides stall: IF/ID always becomes a bubble, pc fields untouched.
      instr_IFOut <= NOP_INSTR;
      valid_IFOut <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (imemReady) begin
            pc_q    <= branchTarget_EX;
            state_q <= StFetch;
          end else begin
            redirect_pc_q <= branchTarget_EX;
            state_q       <= StDrain;
          end
        end
        StHold: begin
          pc_q    <= branchTarget_EX;
          state_q <= StFetch;
        end
        StDrain: begin
          redirect_pc_q <= branchTarget_EX;
          if (imemReady) begin
            pc_q    <= branchTarget_EX;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imemReady && !stall_ID) begin
            pc_IFOut      <= pc_q;
            pcPlus4_IFOut <= pc_plus4;
            instr_IFOut   <= imemData;
            valid_IFOut   <= 1'b1;
            pc_q          <= pc_plus4;
          end else if (imemReady && stall_ID) begin
            hold_buf_q <= imemData;
            state_q    <= StHold;
          end else if (!stall_ID) begin
            instr_IFOut <= NOP_INSTR;
            valid_IFOut <= 1'b0;
          end
        end
        StHold: begin
          if (!stall_ID) begin
            pc_IFOut      <= pc_q;
            pcPlus4_IFOut <= pc_plus4;
            instr_IFOut   <= hold_buf_q;
            valid_IFOut   <= 1'b1;
            pc_q          <= pc_plus4;
            state_q       <= StFetch;
          end
        end
        StDrain: begin
          if (!stall_ID) begin
            instr_IFOut <= NOP_INSTR;
            valid_IFOut <= 1'b0;
          end
          // The stale response is dropped; fetch resumes at the latest redirect target.
          if (imemReady) begin
            pc_q    <= redirect_pc_q;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/hold, redirects, drain, flush-in-hold, wrap.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        stall_ID;
  logic        flush_EX;
  logic [31:0] branchTarget_EX;
  logic [31:0] pc_IFOut;
  logic [31:0] pcPlus4_IFOut;
  logic [31:0] instr_IFOut;
  logic        valid_IFOut;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready;
  logic [31:0] w_data;
  logic        w_stall;
  logic        w_flush;
  logic [31:0] w_target;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemReady      (imemReady),
    .imemData       (imemData),
    .stall_ID       (stall_ID),
    .flush_EX       (flush_EX),
    .branchTarget_EX(branchTarget_EX),
    .pc_IFOut       (pc_IFOut),
    .pcPlus4_IFOut  (pcPlus4_IFOut),
    .instr_IFOut    (instr_IFOut),
    .valid_IFOut    (valid_IFOut)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFF8)
  ) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .imemReq        (w_req),
    .imemAddr       (w_addr),
    .imemReady      (w_ready),
    .imemData       (w_data),
    .stall_ID       (w_stall),
    .flush_EX       (w_flush),
    .branchTarget_EX(w_target),
    .pc_IFOut       (w_pc),
    .pcPlus4_IFOut  (w_pc4),
    .instr_IFOut    (w_instr),
    .valid_IFOut    (w_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    imemReady       = 1'b0;
    imemData        = 32'h0;
    stall_ID        = 1'b0;
    flush_EX        = 1'b0;
    branchTarget_EX = 32'h0;
    w_ready         = 1'b1;
    w_data          = 32'h0000_0093;
    w_stall         = 1'b0;
    w_flush         = 1'b0;
    w_target        = 32'h0;

    #2;
    check("rst_valid", {31'h0, valid_IFOut}, 32'h0);
    check("rst_instr", instr_IFOut, Nop);
    check("rst_pc", pc_IFOut, 32'h0);
    check("rst_pc4", pcPlus4_IFOut, 32'h0);
    rst = 1'b0;
    check("first_req", {31'h0, imemReq}, 32'h1);
    check("first_addr", imemAddr, 32'h0);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFF8);

    // Zero-wait streaming
    imemReady = 1'b1;
    imemData  = 32'h0010_0093;
    tick();
    check("s1_addr", imemAddr, 32'h4);
    check("s1_pc", pc_IFOut, 32'h0);
    check("s1_pc4", pcPlus4_IFOut, 32'h4);
    check("s1_instr", instr_IFOut, 32'h0010_0093);
    check("s1_valid", {31'h0, valid_IFOut}, 32'h1);
    check("wrap1_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap1_pc", w_pc, 32'hFFFF_FFF8);
    check("wrap1_instr", w_instr, 32'h0000_0093);
    imemData = 32'h0020_0113;
    tick();
    check("s2_addr", imemAddr, 32'h8);
    check("s2_pc", pc_IFOut, 32'h4);
    check("s2_instr", instr_IFOut, 32'h0020_0113);
    check("wrap2_addr", w_addr, 32'h0);
    check("wrap2_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap2_pc4", w_pc4, 32'h0);

    // Stall while the response for pc 8 arrives: parked in the hold buffer
    imemData = 32'h0050_0093;
    stall_ID = 1'b1;
    tick();
    check("st1_req", {31'h0, imemReq}, 32'h0);
    check("st1_pc", pc_IFOut, 32'h4);
    check("st1_instr", instr_IFOut, 32'h0020_0113);
    check("st1_valid", {31'h0, valid_IFOut}, 32'h1);
    imemReady = 1'b0;
    imemData  = 32'hDEAD_0000;
    tick();
    check("st2_req", {31'h0, imemReq}, 32'h0);
    check("st2_pc", pc_IFOut, 32'h4);
    stall_ID = 1'b0;
    tick();
    check("rel_pc", pc_IFOut, 32'h8);
    check("rel_instr", instr_IFOut, 32'h0050_0093);
    check("rel_valid", {31'h0, valid_IFOut}, 32'h1);
    check("rel_req", {31'h0, imemReq}, 32'h1);
    check("rel_addr", imemAddr, 32'hC);

    // Zero-wait redirect at pc 0x10
    imemReady = 1'b1;
    imemData  = 32'h0030_0193;
    tick();
    check("pre_flush_addr", imemAddr, 32'h10);
    flush_EX        = 1'b1;
    branchTarget_EX = 32'h100;
    imemData        = 32'h0040_0213;
    tick();
    check("fl_addr", imemAddr, 32'h100);
    check("fl_valid", {31'h0, valid_IFOut}, 32'h0);
    check("fl_instr", instr_IFOut, Nop);
    check("fl_pc_kept", pc_IFOut, 32'hC);

    // Move to 0x20, then redirect to 0x200 during a slow fetch
    branchTarget_EX = 32'h20;
    tick();
    check("to20_addr", imemAddr, 32'h20);
    flush_EX  = 1'b0;
    imemReady = 1'b0;
    tick();
    check("slow1_addr", imemAddr, 32'h20);
    check("slow1_valid", {31'h0, valid_IFOut}, 32'h0);
    flush_EX        = 1'b1;
    branchTarget_EX = 32'h200;
    tick();
    check("dr1_addr", imemAddr, 32'h20);
    check("dr1_req", {31'h0, imemReq}, 32'h1);
    flush_EX = 1'b0;
    tick();
    check("dr2_addr", imemAddr, 32'h20);
    check("dr2_valid", {31'h0, valid_IFOut}, 32'h0);
    imemReady = 1'b1;
    imemData  = 32'hDEAD_BEEF;
    tick();
    check("dr_done_addr", imemAddr, 32'h200);
    check("dr_done_valid", {31'h0, valid_IFOut}, 32'h0);
    check("dr_done_instr", instr_IFOut, Nop);

    // Flush and stall together in HOLD: flush wins, buffered word dropped
    stall_ID = 1'b1;
    imemData = 32'h1111_1111;
    tick();
    check("hf_hold_req", {31'h0, imemReq}, 32'h0);
    flush_EX        = 1'b1;
    branchTarget_EX = 32'h300;
    tick();
    check("hf_addr", imemAddr, 32'h300);
    check("hf_req", {31'h0, imemReq}, 32'h1);
    check("hf_valid", {31'h0, valid_IFOut}, 32'h0);
    check("hf_instr", instr_IFOut, Nop);
    flush_EX = 1'b0;
    stall_ID = 1'b0;
    imemData = 32'h2222_2222;
    tick();
    check("after_hf_instr", instr_IFOut, 32'h2222_2222);
    check("after_hf_pc", pc_IFOut, 32'h300);
    check("after_hf_pc4", pcPlus4_IFOut, 32'h304);
    check("after_hf_addr", imemAddr, 32'h304);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, valid_IFOut}, 32'h0);
    check("arst_addr", imemAddr, 32'h0);
    check("arst_instr", instr_IFOut, Nop);
    check("arst_pc", pc_IFOut, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
